// File: rtl/recv_buffer_bank.sv
// Receive slot buffer: RDMA beats fill SLOTS round-robin slots that the host drains over Avalon-MM.
// Defining RECV_BUFFER_BANK_IRQ_EN adds a registered irq output.
module recv_buffer_bank #(
  parameter int SLOTS = 8,
  parameter int DEPTH = 32,
  parameter int LENW  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [9:0]        address,
  input  logic              clken,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [255:0]      writedata,
  input  logic [31:0]       byteenable,
  output logic [255:0]      readdata,
  input  logic [255:0]      dataIn,
  input  logic              dataPush,
  input  logic              dataLast,
  output logic              ready,
`ifdef RECV_BUFFER_BANK_IRQ_EN
  output logic              irq,
`endif
  output logic [SLOTS-1:0]  fullArray
);
  localparam int SW = $clog2(SLOTS);
  localparam int BW = $clog2(DEPTH);
  localparam logic [LENW-1:0] DEPTH_LEN = LENW'(DEPTH);

  typedef enum logic [1:0] {FREE = 2'd0, FILLING = 2'd1, FULL = 2'd2} slotState_t;

  slotState_t       state_r [SLOTS];
  logic [LENW-1:0]  len_r   [SLOTS];
  logic [255:0]     mem_r   [SLOTS*DEPTH];
  logic [SW-1:0]    wSlot_r;
  logic [SW-1:0]    rSlot_r;
  logic             overflow_r;

  logic [LENW-1:0]  wLen_s;
  logic [LENW-1:0]  wLenNext_s;
  logic [LENW-1:0]  rLen_s;
  logic             ready_s;
  logic             pushOk_s;
  logic             drop_s;
  logic             close_s;
  logic             cmd_s;
  logic             release_s;
  logic             clrOvf_s;
  logic             rdAccess_s;
  logic [SLOTS-1:0] full_s;
  logic [BW-1:0]    rdBeat_s;
  logic [255:0]     rdData_s;
  logic             unusedBits_s;

  assign unusedBits_s = ^{writedata[255:2], byteenable[31:1]};
  assign fullArray    = full_s;
  assign ready        = ready_s;

  // Write-side acceptance and host command decode
  always_comb begin
    full_s = '0;
    for (int i = 0; i < SLOTS; i++) begin
      full_s[i] = (state_r[i] == FULL);
    end
    wLen_s     = len_r[wSlot_r];
    wLenNext_s = wLen_s + LENW'(1);
    ready_s    = (state_r[wSlot_r] != FULL);
    pushOk_s   = dataPush & ready_s;
    drop_s     = dataPush & ~ready_s;
    close_s    = pushOk_s & (dataLast | (wLenNext_s == DEPTH_LEN));
    cmd_s      = chipselect & write & clken & (address == 10'd0) & byteenable[0];
    release_s  = cmd_s & writedata[0] & (state_r[rSlot_r] == FULL);
    clrOvf_s   = cmd_s & writedata[1];
    rdAccess_s = chipselect & read & clken;
  end

  // Read mux: status word at address 0, beats of the oldest slot above it
  always_comb begin
    rLen_s   = len_r[rSlot_r];
    rdBeat_s = BW'(address - 10'd1);
    rdData_s = '0;
    if (address == 10'd0) begin
      rdData_s[SLOTS-1:0] = full_s;
      rdData_s[19:16]     = 4'(rSlot_r);
      rdData_s[20]        = (state_r[rSlot_r] == FULL);
      rdData_s[21]        = overflow_r;
      rdData_s[47:32]     = 16'(rLen_s);
    end else if (16'(address) <= 16'(rLen_s)) begin
      rdData_s = mem_r[{rSlot_r, rdBeat_s}];
    end else begin
      rdData_s = '0;
    end
  end

  // Slot states, lengths, pointers, overflow flag and the read data register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        state_r[i] <= FREE;
        len_r[i]   <= '0;
      end
      wSlot_r    <= '0;
      rSlot_r    <= '0;
      overflow_r <= 1'b0;
      readdata   <= '0;
    end else begin
      if (pushOk_s) begin
        len_r[wSlot_r]   <= wLenNext_s;
        state_r[wSlot_r] <= close_s ? FULL : FILLING;
      end
      if (close_s) begin
        wSlot_r <= wSlot_r + SW'(1);
      end
      // A release only hits a FULL slot, so it never shares an index with an accepted push
      if (release_s) begin
        state_r[rSlot_r] <= FREE;
        len_r[rSlot_r]   <= '0;
        rSlot_r          <= rSlot_r + SW'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clrOvf_s) begin
        overflow_r <= 1'b0;
      end
      if (rdAccess_s) begin
        readdata <= rdData_s;
      end
    end
  end

  // Beat storage; contents are meaningless until covered by a slot length
  always_ff @(posedge clock) begin
    if (pushOk_s) begin
      mem_r[{wSlot_r, wLen_s[BW-1:0]}] <= dataIn;
    end
  end

`ifdef RECV_BUFFER_BANK_IRQ_EN
  // irq follows its causes one cycle later
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (state_r[rSlot_r] == FULL) | overflow_r;
    end
  end
`endif

endmodule

// File: tb/tb_recv_buffer_bank.sv
// Self-checking bench for recv_buffer_bank: vector table, corner sequences and a random run
// compared against a slot-level reference model.
module tb_recv_buffer_bank;
  localparam int SLOTS = 8;
  localparam int DEPTH = 32;
  localparam int LENW  = 10;

  logic             clock;
  logic             reset;
  logic [9:0]       address;
  logic             clken;
  logic             chipselect;
  logic             read;
  logic             write;
  logic [255:0]     writedata;
  logic [31:0]      byteenable;
  logic [255:0]     readdata;
  logic [255:0]     dataIn;
  logic             dataPush;
  logic             dataLast;
  logic             ready;
  logic [SLOTS-1:0] fullArray;
`ifdef RECV_BUFFER_BANK_IRQ_EN
  logic             irq;
`endif

  recv_buffer_bank #(.SLOTS(SLOTS), .DEPTH(DEPTH), .LENW(LENW)) dut (
    .clock(clock), .reset(reset), .address(address), .clken(clken),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .dataIn(dataIn),
    .dataPush(dataPush), .dataLast(dataLast), .ready(ready),
`ifdef RECV_BUFFER_BANK_IRQ_EN
    .irq(irq),
`endif
    .fullArray(fullArray)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: each slot is a list of beats plus a full flag
  logic [255:0] mData [SLOTS][DEPTH];
  int           mLen  [SLOTS];
  bit           mFull [SLOTS];
  int           mW;
  int           mR;
  bit           mOvf;
  bit           mIrq;
  logic [255:0] mRd;

  typedef struct {
    bit          push;
    bit          last;
    logic [7:0]  din;
    bit          rd;
    bit          wr;
    logic [9:0]  addr;
    logic [1:0]  wd;
    logic [7:0]  expFull;
    bit          expReady;
    logic [63:0] expRd;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(bit push, bit last, logic [7:0] din, bit rd, bit wr,
                              logic [9:0] addr, logic [1:0] wd, logic [7:0] ef, bit er,
                              logic [63:0] ed);
    vec_t v;
    v.push = push; v.last = last; v.din = din; v.rd = rd; v.wr = wr;
    v.addr = addr; v.wd = wd; v.expFull = ef; v.expReady = er; v.expRd = ed;
    return v;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [SLOTS-1:0] mFullVec();
    logic [SLOTS-1:0] v;
    v = '0;
    for (int i = 0; i < SLOTS; i++) v[i] = mFull[i];
    return v;
  endfunction

  function automatic logic [255:0] mStatus();
    logic [255:0] s;
    s = '0;
    s[SLOTS-1:0] = mFullVec();
    s[19:16] = 4'(mR);
    s[20] = mFull[mR];
    s[21] = mOvf;
    s[47:32] = 16'(mLen[mR]);
    return s;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < SLOTS; i++) begin
      mLen[i] = 0;
      mFull[i] = 1'b0;
    end
    mW = 0; mR = 0; mOvf = 1'b0; mIrq = 1'b0; mRd = '0;
  endtask

  // Apply one clock of the current inputs to the model (all decisions use pre-edge state)
  task automatic modelStep();
    bit rdAcc, cmd, rel, acc, drop, irqNext;
    int k;
    rdAcc = chipselect && read && clken;
    cmd = chipselect && write && clken && (address == 10'd0) && byteenable[0];
    rel = cmd && writedata[0] && mFull[mR];
    acc = dataPush && !mFull[mW];
    drop = dataPush && mFull[mW];
    irqNext = mFull[mR] || mOvf;
    if (rdAcc) begin
      k = int'(address);
      if (k == 0) mRd = mStatus();
      else if (k <= mLen[mR]) mRd = mData[mR][k-1];
      else mRd = '0;
    end
    if (acc) begin
      mData[mW][mLen[mW]] = dataIn;
      mLen[mW] = mLen[mW] + 1;
      if (dataLast || mLen[mW] == DEPTH) begin
        mFull[mW] = 1'b1;
        mW = (mW + 1) % SLOTS;
      end
    end
    if (rel) begin
      mFull[mR] = 1'b0;
      mLen[mR] = 0;
      mR = (mR + 1) % SLOTS;
    end
    if (drop) mOvf = 1'b1;
    else if (cmd && writedata[1]) mOvf = 1'b0;
    mIrq = irqNext;
  endtask

  task automatic setIdle();
    dataPush = 1'b0; dataLast = 1'b0; dataIn = '0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1;
    address = 10'd0; writedata = '0; byteenable = 32'hFFFF_FFFF;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clock);
    #1;
  endtask

  task automatic push(logic [255:0] d, bit last);
    setIdle(); dataPush = 1'b1; dataLast = last; dataIn = d; tick();
  endtask

  task automatic rdA(logic [9:0] a);
    setIdle(); chipselect = 1'b1; read = 1'b1; address = a; tick();
  endtask

  task automatic cmdW(logic [1:0] wd);
    setIdle(); chipselect = 1'b1; write = 1'b1; writedata = 256'(wd); tick();
  endtask

  task automatic doReset();
    reset = 1'b0;
    modelReset();
    #2;
    reset = 1'b1;
  endtask

  task automatic checkModel(string tag);
    chk($sformatf("%s.readdata", tag), readdata, mRd);
    chk($sformatf("%s.fullArray", tag), 256'(fullArray), 256'(mFullVec()));
    chk($sformatf("%s.ready", tag), 256'(ready), 256'(!mFull[mW]));
`ifdef RECV_BUFFER_BANK_IRQ_EN
    chk($sformatf("%s.irq", tag), 256'(irq), 256'(mIrq));
`endif
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'd0,  2'd1, 8'h00, 1'b1, 64'h0);
    vecs[1]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0,  2'd0, 8'h00, 1'b1, 64'h0);
    vecs[2]  = mk(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 10'd0,  2'd0, 8'h00, 1'b1, 64'h0);
    vecs[3]  = mk(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0, 10'd0,  2'd0, 8'h00, 1'b1, 64'h0);
    vecs[4]  = mk(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 10'd0,  2'd0, 8'h01, 1'b1, 64'h0);
    vecs[5]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0,  2'd0, 8'h01, 1'b1, 64'h0000_0003_0010_0001);
    vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'd2,  2'd0, 8'h01, 1'b1, 64'hA2);
    vecs[7]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'd3,  2'd0, 8'h01, 1'b1, 64'hA3);
    vecs[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0,  2'd0, 8'h01, 1'b1, 64'hA3);
    vecs[9]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'd33, 2'd0, 8'h01, 1'b1, 64'h0);
    vecs[10] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'd1,  2'd0, 8'h01, 1'b1, 64'hA1);
    vecs[11] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'd4,  2'd0, 8'h01, 1'b1, 64'h0);
    vecs[12] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 10'd0,  2'd1, 8'h00, 1'b1, 64'h0);
    vecs[13] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0,  2'd0, 8'h00, 1'b1, 64'h0000_0000_0001_0000);

    setIdle();
    reset = 1'b0;
    modelReset();
    #12;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("reset.readdata", readdata, 256'd0);
    chk("reset.fullArray", 256'(fullArray), 256'd0);
    chk("reset.ready", 256'(ready), 256'd1);

    // Table: first message, status and data reads, release handling
    for (int i = 0; i < 14; i++) begin
      setIdle();
      dataPush = vecs[i].push;
      dataLast = vecs[i].last;
      dataIn = 256'(vecs[i].din);
      if (vecs[i].rd) begin
        chipselect = 1'b1; read = 1'b1; address = vecs[i].addr;
      end
      if (vecs[i].wr) begin
        chipselect = 1'b1; write = 1'b1; address = 10'd0; writedata = 256'(vecs[i].wd);
      end
      tick();
      chk($sformatf("vec%0d.readdata", i), readdata, 256'(vecs[i].expRd));
      chk($sformatf("vec%0d.fullArray", i), 256'(fullArray), 256'(vecs[i].expFull));
      chk($sformatf("vec%0d.ready", i), 256'(ready), 256'(vecs[i].expReady));
    end

    // All slots full, overflow drop, overflow clear
    doReset();
    for (int i = 0; i < SLOTS; i++) push(256'(8'h10 + i), 1'b1);
    chk("ovf.fullArray", 256'(fullArray), 256'hFF);
    chk("ovf.ready", 256'(ready), 256'd0);
    push(256'h99, 1'b1);
    checkModel("ovf.drop");
    rdA(10'd0);
    chk("ovf.status", readdata, 256'h0000_0001_0030_00FF);
    rdA(10'd1);
    chk("ovf.slot0data", readdata, 256'h10);
    cmdW(2'd2);
    rdA(10'd0);
    chk("ovf.cleared", readdata, 256'h0000_0001_0010_00FF);
    checkModel("ovf.end");

    // Forced close at DEPTH beats, next push lands in slot 1
    doReset();
    for (int i = 0; i < DEPTH; i++) push(256'(12'h100 + i), 1'b0);
    chk("force.fullArray", 256'(fullArray), 256'h01);
    chk("force.ready", 256'(ready), 256'd1);
    rdA(10'd0);
    chk("force.status", readdata, 256'h0000_0020_0010_0001);
    rdA(10'd32);
    chk("force.lastbeat", readdata, 256'h11F);
    push(256'h777, 1'b0);
    cmdW(2'd1);
    rdA(10'd0);
    chk("force.slot1status", readdata, 256'h0000_0001_0001_0000);
    rdA(10'd1);
    chk("force.slot1beat0", readdata, 256'h777);

    // Final push into slot 7 together with release of slot 0
    doReset();
    for (int i = 0; i < SLOTS-1; i++) push(256'(8'hC0 + i), 1'b1);
    push(256'hC7, 1'b0);
    chk("simul.pre", 256'(fullArray), 256'h7F);
    setIdle();
    dataPush = 1'b1; dataLast = 1'b1; dataIn = 256'hC8;
    chipselect = 1'b1; write = 1'b1; writedata = 256'd1;
    tick();
    chk("simul.fullArray", 256'(fullArray), 256'hFE);
    chk("simul.ready", 256'(ready), 256'd1);
    push(256'hD0, 1'b1);
    chk("simul.wrap", 256'(fullArray), 256'hFF);
    chk("simul.readyLow", 256'(ready), 256'd0);
    rdA(10'd0);
    chk("simul.status", readdata, 256'h0000_0001_0011_00FF);

    // Asynchronous reset in the middle of a message
    doReset();
    push(256'hE1, 1'b0);
    push(256'hE2, 1'b0);
    rdA(10'd1);
    chk("midrst.before", readdata, 256'hE1);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    chk("midrst.readdata", readdata, 256'd0);
    chk("midrst.fullArray", 256'(fullArray), 256'd0);
    chk("midrst.ready", 256'(ready), 256'd1);
`ifdef RECV_BUFFER_BANK_IRQ_EN
    chk("midrst.irq", 256'(irq), 256'd0);
`endif
    @(negedge clock);
    reset = 1'b1;
    push(256'h55, 1'b1);
    chk("midrst.full", 256'(fullArray), 256'h01);
`ifdef RECV_BUFFER_BANK_IRQ_EN
    chk("midrst.irqDelay", 256'(irq), 256'd0);
`endif
    rdA(10'd0);
    chk("midrst.status", readdata, 256'h0000_0001_0010_0001);
`ifdef RECV_BUFFER_BANK_IRQ_EN
    chk("midrst.irqHigh", 256'(irq), 256'd1);
`endif
    rdA(10'd1);
    chk("midrst.beat0", readdata, 256'h55);

    // Random traffic against the model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      setIdle();
      if ($urandom_range(0, 1) == 0) begin
        dataPush = 1'b1;
        dataLast = ($urandom_range(0, 3) == 0);
        dataIn = {8{$urandom}};
      end
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          chipselect = ($urandom_range(0, 9) != 0);
          read = 1'b1;
          clken = ($urandom_range(0, 9) != 0);
          address = 10'($urandom_range(0, DEPTH + 3));
        end
        3, 4: begin
          chipselect = 1'b1;
          write = 1'b1;
          address = ($urandom_range(0, 7) == 0) ? 10'd1 : 10'd0;
          writedata = 256'($urandom_range(0, 3));
          byteenable[0] = ($urandom_range(0, 7) != 0);
        end
        default: begin
          chipselect = 1'b0;
        end
      endcase
      tick();
      checkModel($sformatf("rand%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
